// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Fetch port, load/store data port and single-port RAM bus
//               shared by the RAM arbiter and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              ram_cs;
    logic              ram_oe;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               ram_cs, ram_oe, ram_we, ram_addr, ram_din
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               ram_cs, ram_oe, ram_we, ram_addr, ram_din
    );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Arbitrates fetch and data ports onto one registered-read RAM;
//               one access per cycle, read data returned two cycles after grant.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int D_PRIORITY = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ram_arbiter_if.slave    bus
);

    logic              w_d_win;
    logic              w_i_gnt;
    logic              w_d_gnt;

    logic              r_cs;
    logic              r_oe;
    logic              r_we;
    logic              r_own_d;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_i_rvalid;
    logic              r_d_rvalid;

    generate
        if (D_PRIORITY != 0) begin : g_fixed
            assign w_d_win = bus.d_req;
        end else begin : g_rr
            // Reset to "data last" so fetch takes the first contention.
            logic r_last_i;

            assign w_d_win = bus.d_req & (~bus.i_req | r_last_i);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_last_i <= 1'b0;
                end else if (w_i_gnt || w_d_gnt) begin
                    r_last_i <= w_i_gnt;
                end
            end
        end
    endgenerate

    assign w_i_gnt = bus.i_req & ~w_d_win & rst_n;
    assign w_d_gnt = bus.d_req &  w_d_win & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cs       <= 1'b0;
            r_oe       <= 1'b0;
            r_we       <= 1'b0;
            r_own_d    <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
        end else begin
            r_cs    <= w_i_gnt | w_d_gnt;
            r_oe    <= w_i_gnt | (w_d_gnt & ~bus.d_we);
            r_we    <= w_d_gnt & bus.d_we;
            r_own_d <= w_d_gnt;
            // Address/data hold on idle cycles; fetch never carries write data.
            if (w_d_gnt) begin
                r_addr <= bus.d_addr;
                r_din  <= bus.d_wdata;
            end else if (w_i_gnt) begin
                r_addr <= bus.i_addr;
            end
            r_i_rvalid <= r_oe & ~r_own_d;
            r_d_rvalid <= r_oe &  r_own_d;
        end
    end

    assign bus.i_gnt    = w_i_gnt;
    assign bus.d_gnt    = w_d_gnt;
    assign bus.ram_cs   = r_cs;
    assign bus.ram_oe   = r_oe;
    assign bus.ram_we   = r_we;
    assign bus.ram_addr = r_addr;
    assign bus.ram_din  = r_din;
    assign bus.i_rvalid = r_i_rvalid;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.i_rdata  = bus.ram_dout;
    assign bus.d_rdata  = bus.ram_dout;

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer sharing the single-port 16-bit RAM (cs/oe/we, registered read) between the CPU instruction-fetch port (read-only) and the load/store data port (read/write).
- Accepts at most one request per cycle and drives the RAM control, address and write data from a registered access stage.
- Returns read data with a fixed 2-cycle latency; fully pipelined, so back-to-back grants sustain one access per cycle.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- D_PRIORITY, 1, 1 = data port always wins on contention; 0 = round-robin between the two ports

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- i_req  in  1  fetch read request
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid (reads only)
- d_rdata  out  DATA_W  data read data
- ram_cs, ram_oe, ram_we  out  1 each  RAM controls
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data (valid the cycle after a read access cycle)

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low.
- Arbitration is combinational in cycle N:
  - gnt = req & winner & rst_n; at most one of i_gnt/d_gnt high.
  - Requesters hold req, addr, we and wdata stable until gnt is seen.
  - D_PRIORITY=1: d_req beats i_req; fetch may starve under continuous d_req.
  - D_PRIORITY=0: on contention, grant the port not granted last; the last-grant register updates only on a grant.
- Stage 1 (access), cycle N+1, registered from the granted request:
  - ram_cs=1; ram_addr and ram_din come from the request.
  - Read: ram_oe=1, ram_we=0. Write: ram_we=1, ram_oe=0.
  - Fetch requests are always reads.
- Stage 2 (response), cycle N+2, for reads only: owner's rvalid=1 for exactly one cycle.
  - Read data: i_rdata = d_rdata = ram_dout (combinational); the value is valid only while the corresponding rvalid is high.
- Writes produce no response. The write is committed at the end of N+1.
- Cycles with no grant: stage 1 drives ram_cs=ram_oe=ram_we=0; ram_addr and ram_din hold their last value.
- Back-to-back operation:
  - A grant is possible every cycle, and per-port response order matches grant order.
  - A read granted at N+1 after a write granted at N to the same address returns the new data at N+3.
- Reset (rst_n sampled low at an edge):
  - Clears stage-1 and stage-2 registers: ram_cs/oe/we=0, ram_addr=0, ram_din=0, i_rvalid=d_rvalid=0.
  - Round-robin state reset so fetch wins the first contention.
  - In-flight reads produce no rvalid.
  - A request granted in the cycle before the reset edge is dropped; its write never reaches the RAM.
  - While rst_n is low, both gnt outputs are 0.
- Simultaneous requests in the same cycle: exactly one grant. The loser sees gnt=0, keeps req high, and is granted in a later cycle.

Test Plan:
- Preload RAM[7..12] = 0x0007..0x000C; fetch reads 7..12 back-to-back with i_req held high → i_gnt high 6 consecutive cycles; i_rvalid high on 6 consecutive cycles starting 2 after the first grant, with i_rdata = 0x0007..0x000C in order.
- Data write 0xDEAD to addr 5, then data read of addr 5 on the next cycle → ram_we pulse with ram_addr=5 and ram_din=0xDEAD; d_rvalid 2 cycles after the read grant with d_rdata=0xDEAD; i_rvalid stays 0.
- D_PRIORITY=1: i_req and d_req both high for 4 cycles, data reads of addr 7..10 → d_gnt on all 4 cycles; i_gnt=0 until d_req drops, then granted next cycle.
- D_PRIORITY=0: both requests held for 4 cycles → grants alternate I,D,I,D; each port's rvalid and rdata go only to the granted port.
- Read granted at cycle N, rst_n low at the edge ending N+1 → no i_rvalid/d_rvalid; ram_cs=0 after that edge; a write granted in cycle N+1 never asserts ram_we; RAM content unchanged.
- Idle with no requests for 5 cycles → ram_cs=ram_oe=ram_we=0; both gnt and both rvalid stay 0.
